// File: rtl/dpram_pipelined_if.sv
// Request/response bundle for dpram_pipelined: two access ports, clear control and status.
// The master side drives requests; the slave side is the RAM.
interface dpram_pipelined_if #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BYTE_WIDTH = 8
);
    localparam int unsigned NBYTES = DATA_WIDTH / BYTE_WIDTH;

    logic [DATA_WIDTH-1:0] in_a;
    logic [DATA_WIDTH-1:0] in_b;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic                  en_a;
    logic                  en_b;
    logic [NBYTES-1:0]     we_a;
    logic [NBYTES-1:0]     we_b;
    logic                  clear;
    logic                  busy;
    logic [DATA_WIDTH-1:0] out_a;
    logic [DATA_WIDTH-1:0] out_b;
    logic                  valid_a;
    logic                  valid_b;
    logic                  collision;

    modport master (
        output in_a, in_b, addr_a, addr_b, en_a, en_b, we_a, we_b, clear,
        input  busy, out_a, out_b, valid_a, valid_b, collision
    );

    modport slave (
        input  in_a, in_b, addr_a, addr_b, en_a, en_b, we_a, we_b, clear,
        output busy, out_a, out_b, valid_a, valid_b, collision
    );
endinterface

// File: rtl/dpram_pipelined.sv
// True dual-port RAM with byte enables, fixed-latency pipelined read-out and a zero-fill sweep.
// Define DPRAM_COLLISION_EN to build the sticky same-address collision flag.
module dpram_pipelined #(
    parameter int unsigned ADDR_WIDTH   = 11,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned BYTE_WIDTH   = 8,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned WRITE_MODE   = 0
) (
    input logic              clk,
    input logic              rst,
    dpram_pipelined_if.slave bus
);
    localparam int unsigned NBYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
    localparam int unsigned NPORTS = 2;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [NBYTES-1:0]     be_t;
    typedef enum logic {StIdle, StClear} state_e;

    state_e state_q, state_d;
    addr_t  sweep_q, sweep_d;
    logic   busy;
    word_t  mem_q [DEPTH];

    // Index 0 is port A, index 1 is port B.
    logic  en    [NPORTS];
    addr_t addr  [NPORTS];
    be_t   we    [NPORTS];
    word_t wdat  [NPORTS];
    logic  acc   [NPORTS];
    logic  wr    [NPORTS];
    word_t old   [NPORTS];
    word_t mask  [NPORTS];
    word_t mrg   [NPORTS];
    word_t rd    [NPORTS];
    logic  same_wr;
    word_t wr_b;

    logic  vld_q [NPORTS][READ_LATENCY];
    word_t dat_q [NPORTS][READ_LATENCY];

    assign en[0]   = bus.en_a;
    assign en[1]   = bus.en_b;
    assign addr[0] = bus.addr_a;
    assign addr[1] = bus.addr_b;
    assign we[0]   = bus.we_a;
    assign we[1]   = bus.we_b;
    assign wdat[0] = bus.in_a;
    assign wdat[1] = bus.in_b;

    // Sweep FSM
    assign busy = (state_q == StClear);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StClear;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        unique case (state_q)
            StIdle: begin
                if (bus.clear) begin
                    state_d = StClear;
                    sweep_d = '0;
                end
            end
            StClear: begin
                // Stop at the top address rather than wrapping back to 0.
                if (sweep_q == '1) begin
                    state_d = StIdle;
                end else begin
                    sweep_d = sweep_q + ADDR_WIDTH'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Per-port access decode and read-data selection
    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        assign acc[p] = en[p] & ~busy & ~rst;
        assign wr[p]  = acc[p] & (|we[p]);
        assign old[p] = mem_q[addr[p]];

        for (genvar b = 0; b < NBYTES; b++) begin : g_mask
            assign mask[p][b*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{we[p][b]}};
        end

        assign mrg[p] = (old[p] & ~mask[p]) | (wdat[p] & mask[p]);
        assign rd[p]  = (WRITE_MODE == 1) ? mrg[p] : old[p];

        for (genvar s = 0; s < READ_LATENCY; s++) begin : g_stage
            if (s == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) begin
                        vld_q[p][0] <= 1'b0;
                        dat_q[p][0] <= '0;
                    end else begin
                        vld_q[p][0] <= acc[p];
                        if (acc[p]) begin
                            dat_q[p][0] <= rd[p];
                        end
                    end
                end
            end else begin : g_next
                // Data only advances with its valid bit so the last stage holds between strobes.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        vld_q[p][s] <= 1'b0;
                        dat_q[p][s] <= '0;
                    end else begin
                        vld_q[p][s] <= vld_q[p][s-1];
                        if (vld_q[p][s-1]) begin
                            dat_q[p][s] <= dat_q[p][s-1];
                        end
                    end
                end
            end
        end
    end

    // Same-address dual write: B's bytes land on top of A's merged word.
    assign same_wr = wr[0] & wr[1] & (addr[0] == addr[1]);
    assign wr_b    = ((same_wr ? mrg[0] : old[1]) & ~mask[1]) | (wdat[1] & mask[1]);

    always_ff @(posedge clk) begin
        if (busy) begin
            mem_q[sweep_q] <= '0;
        end else begin
            if (wr[0]) begin
                mem_q[addr[0]] <= mrg[0];
            end
            if (wr[1]) begin
                mem_q[addr[1]] <= wr_b;
            end
        end
    end

    assign bus.busy    = busy;
    assign bus.out_a   = dat_q[0][READ_LATENCY-1];
    assign bus.out_b   = dat_q[1][READ_LATENCY-1];
    assign bus.valid_a = vld_q[0][READ_LATENCY-1];
    assign bus.valid_b = vld_q[1][READ_LATENCY-1];

`ifdef DPRAM_COLLISION_EN
    logic coll_q;
    logic coll_hit;

    assign coll_hit = acc[0] & acc[1] & (addr[0] == addr[1]) & (wr[0] | wr[1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            coll_q <= 1'b0;
        end else if (coll_hit) begin
            coll_q <= 1'b1;
        end else if (bus.clear) begin
            coll_q <= 1'b0;
        end
    end

    assign bus.collision = coll_q;
`else
    assign bus.collision = 1'b0;
`endif

endmodule

// File: tb/tb_dpram_pipelined.sv
// Self-checking bench for dpram_pipelined: read-first and write-first instances share stimulus
// and are checked against a behavioural memory model through per-port expectation queues.
module tb_dpram_pipelined;
    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 16;
    localparam int unsigned BW    = 8;
    localparam int unsigned RL    = 3;
    localparam int unsigned DEPTH = 16;
`ifdef DPRAM_COLLISION_EN
    localparam bit CollEn = 1'b1;
`else
    localparam bit CollEn = 1'b0;
`endif

    typedef struct {
        int          due;
        logic [15:0] rf;
        logic [15:0] wf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_a, in_b;
    logic [AW-1:0] addr_a, addr_b;
    logic          en_a, en_b;
    logic [1:0]    we_a, we_b;
    logic          clear;

    dpram_pipelined_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW)) if_rf ();
    dpram_pipelined_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW)) if_wf ();

    assign if_rf.in_a   = in_a;
    assign if_rf.in_b   = in_b;
    assign if_rf.addr_a = addr_a;
    assign if_rf.addr_b = addr_b;
    assign if_rf.en_a   = en_a;
    assign if_rf.en_b   = en_b;
    assign if_rf.we_a   = we_a;
    assign if_rf.we_b   = we_b;
    assign if_rf.clear  = clear;
    assign if_wf.in_a   = in_a;
    assign if_wf.in_b   = in_b;
    assign if_wf.addr_a = addr_a;
    assign if_wf.addr_b = addr_b;
    assign if_wf.en_a   = en_a;
    assign if_wf.en_b   = en_b;
    assign if_wf.we_a   = we_a;
    assign if_wf.we_b   = we_b;
    assign if_wf.clear  = clear;

    dpram_pipelined #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .READ_LATENCY(RL), .WRITE_MODE(0)
    ) u_dut_rf (
        .clk(clk),
        .rst(rst),
        .bus(if_rf)
    );

    dpram_pipelined #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .READ_LATENCY(RL), .WRITE_MODE(1)
    ) u_dut_wf (
        .clk(clk),
        .rst(rst),
        .bus(if_wf)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int          cyc = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] apply_we(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                               input logic [1:0] we);
        logic [DW-1:0] r;
        r = o;
        if (we[0]) r[7:0] = n[7:0];
        if (we[1]) r[15:8] = n[15:8];
        return r;
    endfunction

    // Reference model state
    logic [DW-1:0] mem_m [DEPTH];
    exp_t          q_a[$];
    exp_t          q_b[$];
    logic [DW-1:0] last_a_rf = '0, last_a_wf = '0, last_b_rf = '0, last_b_wf = '0;
    int            sweep_left = 0;
    bit            coll_m = 1'b0;
    bit            chk_on = 1'b0;

    // Check what the last edge produced, then predict the next edge from the held inputs.
    always @(negedge clk) begin
        exp_t          e;
        logic          va, vb, acc_a, acc_b;
        logic [DW-1:0] old_a, old_b;
        cyc++;
        if (chk_on) begin
            va = (q_a.size() != 0) && (q_a[0].due == cyc);
            vb = (q_b.size() != 0) && (q_b[0].due == cyc);
            check("valid_a_rf", 32'(if_rf.valid_a), 32'(va));
            check("valid_a_wf", 32'(if_wf.valid_a), 32'(va));
            check("valid_b_rf", 32'(if_rf.valid_b), 32'(vb));
            check("valid_b_wf", 32'(if_wf.valid_b), 32'(vb));
            if (va) begin
                e = q_a.pop_front();
                last_a_rf = e.rf;
                last_a_wf = e.wf;
            end
            if (vb) begin
                e = q_b.pop_front();
                last_b_rf = e.rf;
                last_b_wf = e.wf;
            end
            check("out_a_rf", 32'(if_rf.out_a), 32'(last_a_rf));
            check("out_a_wf", 32'(if_wf.out_a), 32'(last_a_wf));
            check("out_b_rf", 32'(if_rf.out_b), 32'(last_b_rf));
            check("out_b_wf", 32'(if_wf.out_b), 32'(last_b_wf));
            check("busy_rf", 32'(if_rf.busy), 32'(sweep_left > 0));
            check("busy_wf", 32'(if_wf.busy), 32'(sweep_left > 0));
            check("collision_rf", 32'(if_rf.collision), 32'(coll_m));
            check("collision_wf", 32'(if_wf.collision), 32'(coll_m));
        end

        if (rst) begin
            q_a.delete();
            q_b.delete();
            last_a_rf  = '0;
            last_a_wf  = '0;
            last_b_rf  = '0;
            last_b_wf  = '0;
            coll_m     = 1'b0;
            sweep_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
            chk_on = 1'b1;
        end else begin
            acc_a = en_a && (sweep_left == 0);
            acc_b = en_b && (sweep_left == 0);
            old_a = mem_m[addr_a];
            old_b = mem_m[addr_b];
            if (acc_a) begin
                e.due = cyc + RL;
                e.rf  = old_a;
                e.wf  = apply_we(old_a, in_a, we_a);
                q_a.push_back(e);
                mem_m[addr_a] = apply_we(mem_m[addr_a], in_a, we_a);
            end
            if (acc_b) begin
                e.due = cyc + RL;
                e.rf  = old_b;
                e.wf  = apply_we(old_b, in_b, we_b);
                q_b.push_back(e);
                mem_m[addr_b] = apply_we(mem_m[addr_b], in_b, we_b);
            end
            if (CollEn && acc_a && acc_b && addr_a == addr_b && (we_a != 0 || we_b != 0)) begin
                coll_m = 1'b1;
            end else if (clear) begin
                coll_m = 1'b0;
            end
            if (sweep_left > 0) begin
                sweep_left--;
            end else if (clear) begin
                sweep_left = DEPTH;
                for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
            end
        end
    end

    task automatic idle();
        en_a  = 1'b0;
        en_b  = 1'b0;
        we_a  = 2'b00;
        we_b  = 2'b00;
        clear = 1'b0;
    endtask

    task automatic set_a(input logic [1:0] we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        en_a   = 1'b1;
        we_a   = we;
        addr_a = ad;
        in_a   = d;
    endtask

    task automatic set_b(input logic [1:0] we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        en_b   = 1'b1;
        we_b   = we;
        addr_b = ad;
        in_b   = d;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic go();
        wait_cycles(1);
        idle();
    endtask

    initial begin
        idle();
        in_a   = '0;
        in_b   = '0;
        addr_a = '0;
        addr_b = '0;
        rst    = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(18);

        // Everything zero after the power-on sweep
        for (int i = 0; i < DEPTH; i++) begin
            set_a(2'b00, AW'(i), 16'h0);
            set_b(2'b00, AW'(DEPTH - 1 - i), 16'h0);
            go();
        end

        set_a(2'b11, 4'd5, 16'hBEEF);
        go();
        set_b(2'b00, 4'd5, 16'h0);
        go();

        set_a(2'b11, 4'd3, 16'h1234);
        go();
        set_a(2'b01, 4'd3, 16'hFFAB);
        go();
        set_b(2'b00, 4'd3, 16'h0);
        go();

        set_a(2'b11, 4'd2, 16'h0001);
        go();
        set_a(2'b11, 4'd2, 16'h00FF);
        go();

        // Cross-port read while the other port writes
        set_a(2'b11, 4'd9, 16'h7777);
        set_b(2'b00, 4'd9, 16'h0);
        go();
        set_b(2'b00, 4'd9, 16'h0);
        go();

        set_a(2'b11, 4'd7, 16'hAAAA);
        set_b(2'b11, 4'd7, 16'h5555);
        go();
        set_a(2'b00, 4'd7, 16'h0);
        go();
        set_a(2'b11, 4'd8, 16'h1122);
        set_b(2'b10, 4'd8, 16'h3344);
        go();
        set_b(2'b00, 4'd8, 16'h0);
        go();
        wait_cycles(4);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) != 0) set_a(2'($urandom_range(3)), AW'($urandom), DW'($urandom));
            if ($urandom_range(3) != 0) set_b(2'($urandom_range(3)), AW'($urandom), DW'($urandom));
            go();
        end

        // Clear alongside live accesses, then requests and clear pulses during the sweep
        set_a(2'b00, 4'd7, 16'h0);
        set_b(2'b11, 4'd4, 16'hCAFE);
        clear = 1'b1;
        go();
        set_a(2'b00, 4'd4, 16'h0);
        clear = 1'b1;
        go();
        wait_cycles(3);
        clear = 1'b1;
        go();
        wait_cycles(16);
        for (int i = 0; i < DEPTH; i++) begin
            set_a(2'b00, AW'(i), 16'h0);
            go();
        end

        // Reset in mid-sweep restarts it; requests while busy are dropped
        set_a(2'b11, 4'd1, 16'h4242);
        go();
        clear = 1'b1;
        go();
        wait_cycles(9);
        rst = 1'b1;
        set_a(2'b00, 4'd1, 16'h0);
        wait_cycles(1);
        rst = 1'b0;
        wait_cycles(3);
        idle();
        wait_cycles(17);
        set_a(2'b00, 4'd1, 16'h0);
        set_b(2'b00, 4'd1, 16'h0);
        go();

        wait_cycles(RL + 3);
        check("drain_a", 32'(q_a.size()), 32'd0);
        check("drain_b", 32'(q_b.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dpram_pipelined.md
DPRAM_PIPELINED -- requirements
Module: dpram_pipelined

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 11, address bits per port (depth 2**ADDR_WIDTH).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, word width; must be a multiple of BYTE_WIDTH.
REQ-003 The block SHALL have parameter BYTE_WIDTH, default 8, write-enable granularity; NBYTES = DATA_WIDTH/BYTE_WIDTH.
REQ-004 The block SHALL have parameter READ_LATENCY, default 2, range 1..4, cycles from accepted read to out_x valid.
REQ-005 The block SHALL have parameter WRITE_MODE, default 0, where 0 is read-first and 1 is write-first for same-port read-during-write.
REQ-006 The block SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-007 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 The block SHALL have ports in_a/in_b, input, DATA_WIDTH, write data.
REQ-009 The block SHALL have ports addr_a/addr_b, input, ADDR_WIDTH, word address.
REQ-010 The block SHALL have ports en_a/en_b, input, 1, port access request.
REQ-011 The block SHALL have ports we_a/we_b, input, NBYTES, per-byte write enables, honoured only with en_x.
REQ-012 The block SHALL have port clear, input, 1, single-cycle pulse requesting a zero-fill sweep.
REQ-013 The block SHALL have port busy, output, 1, high while a zero-fill sweep runs.
REQ-014 The block SHALL have ports out_a/out_b, output, DATA_WIDTH, read data.
REQ-015 The block SHALL have ports valid_a/valid_b, output, 1, one-cycle strobe qualifying out_x.
REQ-016 The block SHALL have port collision, output, 1, sticky same-address conflict flag.

Function
REQ-017 An access SHALL be accepted when en_x=1 and busy=0; requests while busy=1 SHALL be dropped without side effect.
REQ-018 Every accepted access (read or write) SHALL produce valid_x exactly READ_LATENCY cycles later, carrying data at addr_x.
REQ-019 Accesses SHALL be fully pipelined: one accepted access per port per cycle, no stalls.
REQ-020 out_x SHALL update only on cycles where valid_x=1 and SHALL otherwise hold its last value.
REQ-021 Bytes with we_x[i]=1 SHALL be written; bytes with we_x[i]=0 SHALL retain old contents.
REQ-022 For a same-port write, WRITE_MODE=0 SHALL return pre-write data and WRITE_MODE=1 SHALL return the merged post-write word.
REQ-023 For a cross-port read of an address the other port writes in the same cycle, the read SHALL return pre-write data.
REQ-024 When both ports write the same address in the same cycle, port B's enabled bytes SHALL win and port A's bytes not written by B SHALL be kept.
REQ-025 The FSM SHALL have states IDLE and CLEAR, with IDLE->CLEAR on clear=1 and CLEAR->IDLE after writing address 2**ADDR_WIDTH-1.
REQ-026 In CLEAR, the block SHALL write zero to one address per cycle, ascending from 0, for exactly 2**ADDR_WIDTH cycles, with busy=1 throughout.
REQ-027 clear asserted while in CLEAR SHALL be ignored.
REQ-028 Reads in flight when CLEAR starts SHALL complete normally with their pre-clear data.
REQ-029 The sweep address counter SHALL be ADDR_WIDTH bits and SHALL terminate at its maximum value without wrapping.

Reset
REQ-030 On rst=1, the block SHALL enter CLEAR with the sweep address at 0 and busy=1 on the following cycle.
REQ-031 On rst=1, valid_a, valid_b and all pipeline valid bits SHALL be 0, out_a and out_b SHALL be 0, and collision SHALL be 0.
REQ-032 rst asserted mid-sweep SHALL restart the sweep from address 0.
REQ-033 Memory contents SHALL be undefined until the first sweep completes.

Configuration
REQ-034 With macro DPRAM_COLLISION_EN defined, collision SHALL set when both ports are accepted on the same address with either we nonzero, and SHALL hold until rst or clear.
REQ-035 Without DPRAM_COLLISION_EN, collision SHALL be tied to 0 and no comparison logic SHALL be built.

Verification
REQ-036 Release rst, ADDR_WIDTH=4 -> busy high for exactly 16 cycles; reads of all addresses afterwards return 0.
REQ-037 READ_LATENCY=3: write 0xBEEF to A@5, read B@5 next cycle -> valid_b 3 cycles after the read, out_b=0xBEEF.
REQ-038 Word is 0x1234; write we_a=2'b01, in_a=0xFFAB -> subsequent read returns 0x12AB.
REQ-039 Same-cycle write of 0xAAAA via A and 0x5555 via B to addr 7, with DPRAM_COLLISION_EN -> readback 0x5555 and collision=1 until clear.
REQ-040 WRITE_MODE=1: old value 0x0001, same-port write 0x00FF with read -> out_a=0x00FF; with WRITE_MODE=0 -> out_a=0x0001.
REQ-041 Assert rst at sweep address 9, then issue en_a during busy -> sweep restarts at 0, en_a is dropped, and no valid_a results.
